// File: rtl/atm_pkg.sv
// Shared constants, key codes and FSM encoding for the ATM PIN front end.
package atm_pkg;

  // PIN geometry and lockout threshold
  localparam int PIN_DIGITS = 4;
  localparam int MAX_FAIL   = 3;

  // Derived thresholds sized to the registers that use them
  localparam logic [2:0] CNT_FULL  = 3'(PIN_DIGITS);
  localparam logic [1:0] FAIL_LAST = 2'(MAX_FAIL - 1);

  // Keypad codes (0-9 are plain digits)
  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BACK  = 4'hB;
  localparam logic [3:0] KEY_OPT1  = 4'hC;
  localparam logic [3:0] KEY_OPT2  = 4'hD;
  localparam logic [3:0] KEY_OPT3  = 4'hE;
  localparam logic [3:0] KEY_NONE  = 4'hF;

  // Front-end controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_CHECK   = 2'b10,
    ST_LOCKED  = 2'b11
  } state_t;

  // True when a key code is a decimal digit
  function automatic logic is_bcd_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/atm_key_decode.sv
// Classifies a raw keypad code into digit / enter / back / option classes.
module atm_key_decode
  import atm_pkg::*;
(
  input  logic [3:0] key_code,
  output logic       is_digit,
  output logic       is_enter,
  output logic       is_back,
  output logic       is_opt,
  output logic [1:0] opt_code
);

  // Decode the key class; option keys also yield their 2-bit option code
  always_comb begin
    is_digit = is_bcd_digit(key_code);
    is_enter = 1'b0;
    is_back  = 1'b0;
    is_opt   = 1'b0;
    opt_code = 2'b00;
    case (key_code)
      KEY_ENTER: is_enter = 1'b1;
      KEY_BACK:  is_back  = 1'b1;
      KEY_OPT1: begin
        is_opt   = 1'b1;
        opt_code = 2'b01;
      end
      KEY_OPT2: begin
        is_opt   = 1'b1;
        opt_code = 2'b10;
      end
      KEY_OPT3: begin
        is_opt   = 1'b1;
        opt_code = 2'b11;
      end
      KEY_NONE: is_opt = 1'b0;
      default:  is_opt = 1'b0;
    endcase
  end

endmodule

// File: rtl/atm_pin_frontend.sv
// ATM PIN entry front end: collects up to four digits, checks them against
// the stored PIN, tracks consecutive failures and locks out after too many.
// Every output is a flop; key inputs only feed next-state logic.
module atm_pin_frontend
  import atm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] stored_pin,
  output logic        B,
  output logic        E,
  output logic        V,
  output logic        O2,
  output logic        O1,
  output logic        locked,
  output logic [2:0]  digit_cnt
);

  state_t      state_r, state_s;
  logic [15:0] buf_r, buf_s;
  logic [2:0]  cnt_r, cnt_s;
  logic [1:0]  fail_r, fail_s;
  logic [1:0]  opt_r, opt_s;
  logic        b_r, b_s;
  logic        e_r, e_s;
  logic        v_r, v_s;
  logic        locked_r, locked_s;

  logic        is_digit_s, is_enter_s, is_back_s, is_opt_s;
  logic [1:0]  opt_code_s;
  logic        dig_key_s, ent_key_s, bck_key_s, opt_key_s;
  logic        room_s, match_s, last_fail_s;

  atm_key_decode u_decode (
    .key_code (key_code),
    .is_digit (is_digit_s),
    .is_enter (is_enter_s),
    .is_back  (is_back_s),
    .is_opt   (is_opt_s),
    .opt_code (opt_code_s)
  );

  // Qualified key events and check result terms
  always_comb begin
    dig_key_s   = key_valid & is_digit_s;
    ent_key_s   = key_valid & is_enter_s;
    bck_key_s   = key_valid & is_back_s;
    opt_key_s   = key_valid & is_opt_s;
    room_s      = (cnt_r < CNT_FULL);
    match_s     = (cnt_r == CNT_FULL) && (buf_r == stored_pin);
    last_fail_s = !match_s && (fail_r == FAIL_LAST);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_COLLECT: begin
        if (bck_key_s) begin
          state_s = ST_IDLE;
        end else if (ent_key_s) begin
          state_s = ST_CHECK;
        end else if (dig_key_s && room_s) begin
          state_s = ST_COLLECT;
        end else begin
          state_s = state_r;
        end
      end
      ST_CHECK: begin
        if (last_fail_s) begin
          state_s = ST_LOCKED;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOCKED: state_s = ST_LOCKED;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Output and datapath next values; pulses default low, held values default to hold
  always_comb begin
    buf_s    = buf_r;
    cnt_s    = cnt_r;
    fail_s   = fail_r;
    opt_s    = opt_r;
    b_s      = 1'b0;
    e_s      = 1'b0;
    v_s      = 1'b0;
    locked_s = (state_r == ST_LOCKED);
    case (state_r)
      ST_IDLE, ST_COLLECT: begin
        if (bck_key_s) begin
          b_s   = 1'b1;
          buf_s = 16'h0000;
          cnt_s = 3'd0;
          opt_s = 2'b00;
        end else if (opt_key_s) begin
          opt_s = opt_code_s;
        end else if (dig_key_s && room_s) begin
          buf_s = {buf_r[11:0], key_code};
          cnt_s = cnt_r + 3'd1;
        end else begin
          buf_s = buf_r;
        end
      end
      ST_CHECK: begin
        e_s   = 1'b1;
        v_s   = match_s;
        buf_s = 16'h0000;
        cnt_s = 3'd0;
        if (match_s) begin
          fail_s = 2'd0;
        end else if (fail_r != 2'd3) begin
          fail_s = fail_r + 2'd1;
        end else begin
          fail_s = fail_r;
        end
        if (last_fail_s) begin
          opt_s = 2'b00;
        end else begin
          opt_s = opt_r;
        end
      end
      ST_LOCKED: begin
        buf_s = 16'h0000;
        cnt_s = 3'd0;
        opt_s = 2'b00;
      end
      default: begin
        buf_s    = 16'h0000;
        cnt_s    = 3'd0;
        fail_s   = 2'd0;
        opt_s    = 2'b00;
        locked_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r    <= 16'h0000;
      cnt_r    <= 3'd0;
      fail_r   <= 2'd0;
      opt_r    <= 2'b00;
      b_r      <= 1'b0;
      e_r      <= 1'b0;
      v_r      <= 1'b0;
      locked_r <= 1'b0;
    end else begin
      buf_r    <= buf_s;
      cnt_r    <= cnt_s;
      fail_r   <= fail_s;
      opt_r    <= opt_s;
      b_r      <= b_s;
      e_r      <= e_s;
      v_r      <= v_s;
      locked_r <= locked_s;
    end
  end

  assign B         = b_r;
  assign E         = e_r;
  assign V         = v_r;
  assign O2        = opt_r[1];
  assign O1        = opt_r[0];
  assign locked    = locked_r;
  assign digit_cnt = cnt_r;

endmodule
